// File: rtl/tx_buf_sched_pkg.sv
// tx_buf_sched_pkg: shared types and constants for the ping-pong TX buffer scheduler.
//   half_st_e  - per-half ownership state
//   wr_st_e    - write-port arbiter state
//   HDR_MAGIC  - upper byte of the optional stream-half header word
//   popcnt     - set-bit count, used for frame sizing
package tx_buf_sched_pkg;
    typedef enum logic [1:0] {H_FREE, H_FILL, H_READY, H_SEND} half_st_e;
    typedef enum logic [1:0] {W_IDLE, W_CMD, W_STRM, W_FLUSH} wr_st_e;
    localparam logic [7:0] HDR_MAGIC = 8'hA5;
    localparam int DEF_ADDR_NBIT = 8;
    localparam int DEF_DATA_NBIT = 16;
    localparam int DEF_CHN_NUM = 8;
    localparam int OVF_NBIT = 16;
    function automatic logic [7:0] popcnt(input logic [31:0] v);
        logic [7:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 8'(v[i]);
        return n;
    endfunction
endpackage

// File: rtl/tx_buf_sched_chmask_serializer.sv
// chmask_serializer: one-frame capture register emitting masked channels in ascending order.
//   in : mclk, rst, cfg_stream_en, cfg_chmask, ad_vd, ad_ch_data, ser_rdy
//   out: ser_vld (frame held), ser_data (lowest pending channel), ser_last,
//        ser_fresh (no word of this frame consumed yet), ser_cnt (frame word count), ovf_cnt
module chmask_serializer
    import tx_buf_sched_pkg::*;
#(
    parameter int DATA_NBIT = DEF_DATA_NBIT,
    parameter int CHN_NUM = DEF_CHN_NUM
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic                          cfg_stream_en,
    input  logic [CHN_NUM-1:0]            cfg_chmask,
    input  logic                          ad_vd,
    input  logic [CHN_NUM*DATA_NBIT-1:0]  ad_ch_data,
    input  logic                          ser_rdy,
    output logic                          ser_vld,
    output logic [DATA_NBIT-1:0]          ser_data,
    output logic                          ser_last,
    output logic                          ser_fresh,
    output logic [7:0]                    ser_cnt,
    output logic [OVF_NBIT-1:0]           ovf_cnt
);
    logic [CHN_NUM*DATA_NBIT-1:0] data_q, data_d;
    logic [CHN_NUM-1:0] msk_q, msk_d, rem_q, rem_d, low;
    logic full_q, full_d, take;
    logic [OVF_NBIT-1:0] ovf_q, ovf_d;
    always_comb begin
        // two's-complement trick isolates the lowest pending channel
        low = rem_q & (~rem_q + CHN_NUM'(1));
        ser_data = '0;
        for (int i = 0; i < CHN_NUM; i++)
            if (low[i]) ser_data = data_q[i*DATA_NBIT +: DATA_NBIT];
        ser_vld = full_q;
        ser_last = (rem_q & ~low) == '0;
        ser_fresh = rem_q == msk_q;
        ser_cnt = popcnt(32'(msk_q));
        take = ad_vd && cfg_stream_en && (cfg_chmask != '0);
        data_d = data_q;
        msk_d = msk_q;
        rem_d = rem_q;
        full_d = full_q;
        ovf_d = ovf_q;
        if (full_q && ser_rdy) begin
            rem_d = rem_q & ~low;
            full_d = !ser_last;
        end
        if (take && !full_q) begin
            data_d = ad_ch_data;
            msk_d = cfg_chmask;
            rem_d = cfg_chmask;
            full_d = 1'b1;
        end
        if (take && full_q && ovf_q != '1) ovf_d = ovf_q + OVF_NBIT'(1);
    end
    always_ff @(posedge mclk) begin
        if (rst) begin
            data_q <= '0;
            msk_q <= '0;
            rem_q <= '0;
            full_q <= 1'b0;
            ovf_q <= '0;
        end else begin
            data_q <= data_d;
            msk_q <= msk_d;
            rem_q <= rem_d;
            full_q <= full_d;
            ovf_q <= ovf_d;
        end
    end
    assign ovf_cnt = ovf_q;
endmodule

// File: rtl/tx_buf_sched.sv
// tx_buf_sched: write-side scheduler for the ping-pong TX buffer feeding the USB slave FIFO.
//   in : mclk, rst, cfg_stream_en, cfg_chmask, ad_vd, ad_ch_data,
//        cmd_req, cmd_vd, cmd_data, cmd_eop, tx_done
//   out: cmd_gnt, buf_wren, buf_wraddr {half, word}, buf_wrdata,
//        tx_sop, tx_half, tx_len, ovf_cnt (all registered)
//   Macro TX_BUF_SCHED_HDR_EN: stream halves begin with header {HDR_MAGIC, seq}.
module tx_buf_sched
    import tx_buf_sched_pkg::*;
#(
    parameter int ADDR_NBIT = DEF_ADDR_NBIT,
    parameter int DATA_NBIT = DEF_DATA_NBIT,
    parameter int CHN_NUM = DEF_CHN_NUM
) (
    input  logic                          mclk,
    input  logic                          rst,
    input  logic                          cfg_stream_en,
    input  logic [CHN_NUM-1:0]            cfg_chmask,
    input  logic                          ad_vd,
    input  logic [CHN_NUM*DATA_NBIT-1:0]  ad_ch_data,
    input  logic                          cmd_req,
    output logic                          cmd_gnt,
    input  logic                          cmd_vd,
    input  logic [DATA_NBIT-1:0]          cmd_data,
    input  logic                          cmd_eop,
    output logic                          buf_wren,
    output logic [ADDR_NBIT:0]            buf_wraddr,
    output logic [DATA_NBIT-1:0]          buf_wrdata,
    output logic                          tx_sop,
    output logic                          tx_half,
    output logic [ADDR_NBIT:0]            tx_len,
    input  logic                          tx_done,
    output logic [OVF_NBIT-1:0]           ovf_cnt
);
    localparam int DEPTH = 1 << ADDR_NBIT;
    localparam logic [ADDR_NBIT:0] FULL = {1'b1, {ADDR_NBIT{1'b0}}};
    localparam logic [ADDR_NBIT:0] ONE = {{ADDR_NBIT{1'b0}}, 1'b1};
    wr_st_e st_q, st_d;
    half_st_e hst_q [2], hst_d [2];
    logic [ADDR_NBIT:0] len_q [2], len_d [2];
    logic [ADDR_NBIT:0] cnt_q, cnt_d, waddr_q, waddr_d, tlen_q, tlen_d;
    logic [DATA_NBIT-1:0] wdata_q, wdata_d;
    logic fill_q, fill_d, snd_q, snd_d, en_q, pend_q, pend_d;
    logic wren_q, wren_d, gnt_q, gnt_d, sop_q, sop_d, half_q, half_d;
    logic commit, avail, ser_rdy, ser_vld, ser_last, ser_fresh;
    logic [DATA_NBIT-1:0] ser_data;
    logic [7:0] ser_cnt;
`ifdef TX_BUF_SCHED_HDR_EN
    logic [7:0] seq_q, seq_d;
`endif
    chmask_serializer #(.DATA_NBIT(DATA_NBIT), .CHN_NUM(CHN_NUM)) u_ser (
        .mclk(mclk), .rst(rst), .cfg_stream_en(cfg_stream_en), .cfg_chmask(cfg_chmask),
        .ad_vd(ad_vd), .ad_ch_data(ad_ch_data), .ser_rdy(ser_rdy), .ser_vld(ser_vld),
        .ser_data(ser_data), .ser_last(ser_last), .ser_fresh(ser_fresh), .ser_cnt(ser_cnt),
        .ovf_cnt(ovf_cnt)
    );
    always_comb begin
        st_d = st_q;
        hst_d = hst_q;
        len_d = len_q;
        cnt_d = cnt_q;
        fill_d = fill_q;
        snd_d = snd_q;
        wren_d = 1'b0;
        waddr_d = {fill_q, cnt_q[ADDR_NBIT-1:0]};
        wdata_d = wdata_q;
        commit = 1'b0;
        ser_rdy = 1'b0;
`ifdef TX_BUF_SCHED_HDR_EN
        seq_d = seq_q;
`endif
        avail = hst_q[fill_q] == H_FREE || hst_q[fill_q] == H_FILL;
        // a stream-enable fall is remembered until the partial half is committed
        pend_d = (pend_q || (en_q && !cfg_stream_en)) && st_q != W_FLUSH
                 && !(st_q == W_IDLE && cnt_q == '0);
        unique case (st_q)
            W_IDLE: begin
                if (cmd_req)
                    st_d = cnt_q != '0 ? W_FLUSH : hst_q[fill_q] == H_FREE ? W_CMD : W_IDLE;
                else if (pend_q && cnt_q != '0)
                    st_d = W_FLUSH;
                else if (ser_vld && avail)
                    st_d = W_STRM;
            end
            W_FLUSH: begin
                commit = 1'b1;
                st_d = W_IDLE;
            end
            W_CMD: begin
                if (cmd_vd) begin
                    if (cnt_q != FULL) begin
                        wren_d = 1'b1;
                        wdata_d = cmd_data;
                        cnt_d = cnt_q + ONE;
                    end
                    if (cmd_eop) begin
                        commit = 1'b1;
                        st_d = W_IDLE;
                    end
                end
            end
            W_STRM: begin
                if (!avail || !ser_vld)
                    st_d = W_IDLE;
                else if (ser_fresh && cnt_q != '0 && 32'(cnt_q) + 32'(ser_cnt) > DEPTH)
                    commit = 1'b1;
`ifdef TX_BUF_SCHED_HDR_EN
                else if (cnt_q == '0) begin
                    wren_d = 1'b1;
                    wdata_d = DATA_NBIT'({HDR_MAGIC, seq_q});
                    cnt_d = ONE;
                    seq_d = seq_q + 8'd1;
                end
`endif
                else begin
                    wren_d = 1'b1;
                    wdata_d = ser_data;
                    cnt_d = cnt_q + ONE;
                    ser_rdy = 1'b1;
                    st_d = ser_last ? W_IDLE : W_STRM;
                    commit = cnt_d == FULL;
                end
            end
        endcase
        if (wren_d) hst_d[fill_q] = H_FILL;
        if (commit) begin
            hst_d[fill_q] = H_READY;
            len_d[fill_q] = cnt_d;
            fill_d = !fill_q;
            cnt_d = '0;
        end
        gnt_d = st_d == W_CMD;
        // only the send-pointer half can ever be in SEND; the writer never touches it
        sop_d = 1'b0;
        half_d = half_q;
        tlen_d = tlen_q;
        if (hst_q[snd_q] == H_SEND) begin
            if (tx_done) begin
                hst_d[snd_q] = H_FREE;
                snd_d = !snd_q;
            end
        end else if (hst_q[snd_q] == H_READY) begin
            sop_d = 1'b1;
            hst_d[snd_q] = H_SEND;
            half_d = snd_q;
            tlen_d = len_q[snd_q];
        end
    end
    always_ff @(posedge mclk) begin
        if (rst) begin
            st_q <= W_IDLE;
            hst_q <= '{H_FREE, H_FREE};
            len_q <= '{'0, '0};
            cnt_q <= '0;
            fill_q <= 1'b0;
            snd_q <= 1'b0;
            en_q <= 1'b0;
            pend_q <= 1'b0;
            wren_q <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            gnt_q <= 1'b0;
            sop_q <= 1'b0;
            half_q <= 1'b0;
            tlen_q <= '0;
`ifdef TX_BUF_SCHED_HDR_EN
            seq_q <= '0;
`endif
        end else begin
            st_q <= st_d;
            hst_q <= hst_d;
            len_q <= len_d;
            cnt_q <= cnt_d;
            fill_q <= fill_d;
            snd_q <= snd_d;
            en_q <= cfg_stream_en;
            pend_q <= pend_d;
            wren_q <= wren_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            gnt_q <= gnt_d;
            sop_q <= sop_d;
            half_q <= half_d;
            tlen_q <= tlen_d;
`ifdef TX_BUF_SCHED_HDR_EN
            seq_q <= seq_d;
`endif
        end
    end
    assign cmd_gnt = gnt_q;
    assign buf_wren = wren_q;
    assign buf_wraddr = waddr_q;
    assign buf_wrdata = wdata_q;
    assign tx_sop = sop_q;
    assign tx_half = half_q;
    assign tx_len = tlen_q;
endmodule

// File: tb/tb_tx_buf_sched.sv
// tb_tx_buf_sched: directed self-checking bench for tx_buf_sched (ADDR_NBIT=3).
module tb_tx_buf_sched;
    localparam int AW = 3;
    localparam int DW = 16;
    localparam int CN = 8;
    logic mclk = 1'b0;
    logic rst = 1'b1;
    logic cfg_stream_en = 1'b0;
    logic [CN-1:0] cfg_chmask = '0;
    logic ad_vd = 1'b0;
    logic [CN*DW-1:0] ad_ch_data = '0;
    logic cmd_req = 1'b0, cmd_vd = 1'b0, cmd_eop = 1'b0, tx_done = 1'b0;
    logic [DW-1:0] cmd_data = '0;
    logic cmd_gnt, buf_wren, tx_sop, tx_half;
    logic [AW:0] buf_wraddr, tx_len;
    logic [DW-1:0] buf_wrdata;
    logic [15:0] ovf_cnt;
    int checks = 0;
    int fails = 0;
    int sop_n = 0;
    int wr_n = 0;
    logic [15:0] mem [16];
    logic last_half = 1'b0;
    logic [AW:0] last_len = '0;

    tx_buf_sched #(.ADDR_NBIT(AW), .DATA_NBIT(DW), .CHN_NUM(CN)) dut (
        .mclk(mclk), .rst(rst), .cfg_stream_en(cfg_stream_en), .cfg_chmask(cfg_chmask),
        .ad_vd(ad_vd), .ad_ch_data(ad_ch_data), .cmd_req(cmd_req), .cmd_gnt(cmd_gnt),
        .cmd_vd(cmd_vd), .cmd_data(cmd_data), .cmd_eop(cmd_eop), .buf_wren(buf_wren),
        .buf_wraddr(buf_wraddr), .buf_wrdata(buf_wrdata), .tx_sop(tx_sop), .tx_half(tx_half),
        .tx_len(tx_len), .tx_done(tx_done), .ovf_cnt(ovf_cnt)
    );

    always #5 mclk = ~mclk;

    // buffer image and USB-side event log, sampled mid-cycle
    always @(negedge mclk) begin
        if (rst) begin
            sop_n = 0;
            wr_n = 0;
            for (int i = 0; i < 16; i++) mem[i] = '0;
        end else begin
            if (buf_wren) begin
                mem[buf_wraddr] = buf_wrdata;
                wr_n++;
            end
            if (tx_sop) begin
                sop_n++;
                last_half = tx_half;
                last_len = tx_len;
            end
        end
    end

    function automatic logic [15:0] ev(input int tid, input int f, input int ch);
        return 16'(tid * 4096 + f * 256 + ch);
    endfunction

    task automatic tick;
        @(posedge mclk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        cfg_stream_en = 1'b0;
        cfg_chmask = '0;
        ad_vd = 1'b0;
        cmd_req = 1'b0;
        cmd_vd = 1'b0;
        cmd_eop = 1'b0;
        tx_done = 1'b0;
        repeat (2) tick;
        rst = 1'b0;
    endtask

    task automatic frame(input int tid, input int f);
        for (int i = 0; i < CN; i++) ad_ch_data[i*DW +: DW] = ev(tid, f, i);
        ad_vd = 1'b1;
        tick;
        ad_vd = 1'b0;
    endtask

    task automatic pulse_done;
        tx_done = 1'b1;
        tick;
        tx_done = 1'b0;
    endtask

    task automatic wait_sop(input int n, input string name);
        int k;
        k = 0;
        while (sop_n < n && k < 60) begin
            tick;
            k++;
        end
        checks++;
        if (sop_n < n) begin
            fails++;
            $display("FAIL %s sop timeout: got %0d, want %0d", name, sop_n, n);
        end
    endtask

    task automatic cmd_pkt(input int n, input logic [15:0] base);
        int k;
        k = 0;
        cmd_req = 1'b1;
        while (!cmd_gnt && k < 40) begin
            tick;
            k++;
        end
        cmd_req = 1'b0;
        checks++;
        if (cmd_gnt !== 1'b1) begin
            fails++;
            $display("FAIL cmd_gnt timeout: got %b, want 1", cmd_gnt);
        end
        for (int i = 0; i < n; i++) begin
            cmd_vd = 1'b1;
            cmd_data = base + 16'(i);
            cmd_eop = i == n - 1;
            tick;
        end
        cmd_vd = 1'b0;
        cmd_eop = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        checks++;
        if ({buf_wren, cmd_gnt, tx_sop, tx_half} !== 4'b0) begin
            fails++;
            $display("FAIL reset flags: got %b, want 0000", {buf_wren, cmd_gnt, tx_sop, tx_half});
        end
        checks++;
        if (buf_wraddr !== '0) begin fails++; $display("FAIL reset wraddr: got %h, want 0", buf_wraddr); end
        checks++;
        if (buf_wrdata !== '0) begin fails++; $display("FAIL reset wrdata: got %h, want 0", buf_wrdata); end
        checks++;
        if (tx_len !== '0) begin fails++; $display("FAIL reset tx_len: got %0d, want 0", tx_len); end
        checks++;
        if (ovf_cnt !== '0) begin fails++; $display("FAIL reset ovf_cnt: got %0d, want 0", ovf_cnt); end
    endtask

    task automatic test_fill_half;
        do_reset;
        cfg_stream_en = 1'b1;
        cfg_chmask = 8'h05;
        for (int f = 1; f <= 4; f++) begin
            frame(1, f);
            repeat (8) tick;
        end
        wait_sop(1, "fill");
        checks++;
        if (last_half !== 1'b0) begin fails++; $display("FAIL fill tx_half: got %b, want 0", last_half); end
        checks++;
        if (last_len !== 4'd8) begin fails++; $display("FAIL fill tx_len: got %0d, want 8", last_len); end
        for (int f = 1; f <= 4; f++) begin
            checks++;
            if (mem[2*f-2] !== ev(1, f, 0)) begin
                fails++;
                $display("FAIL fill word%0d: got %h, want %h", 2*f-2, mem[2*f-2], ev(1, f, 0));
            end
            checks++;
            if (mem[2*f-1] !== ev(1, f, 2)) begin
                fails++;
                $display("FAIL fill word%0d: got %h, want %h", 2*f-1, mem[2*f-1], ev(1, f, 2));
            end
        end
    endtask

    task automatic test_frame_split;
        do_reset;
        cfg_stream_en = 1'b1;
        cfg_chmask = 8'h07;
        for (int f = 1; f <= 3; f++) begin
            frame(2, f);
            repeat (8) tick;
        end
        wait_sop(1, "split");
        checks++;
        if (last_len !== 4'd6) begin fails++; $display("FAIL split tx_len: got %0d, want 6", last_len); end
        checks++;
        if (last_half !== 1'b0) begin fails++; $display("FAIL split tx_half: got %b, want 0", last_half); end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (mem[8+c] !== ev(2, 3, c)) begin
                fails++;
                $display("FAIL split half1 word%0d: got %h, want %h", c, mem[8+c], ev(2, 3, c));
            end
        end
        checks++;
        if (mem[5] !== ev(2, 2, 2)) begin fails++; $display("FAIL split word5: got %h, want %h", mem[5], ev(2, 2, 2)); end
        repeat (6) tick;
        checks++;
        if (sop_n !== 1) begin fails++; $display("FAIL split extra sop: got %0d, want 1", sop_n); end
    endtask

    task automatic test_cmd_preempt;
        do_reset;
        cfg_stream_en = 1'b1;
        cfg_chmask = 8'h07;
        frame(3, 1);
        repeat (8) tick;
        cmd_pkt(5, 16'h3C00);
        checks++;
        if (cmd_gnt !== 1'b0) begin fails++; $display("FAIL cmd_gnt drop: got %b, want 0", cmd_gnt); end
        checks++;
        if (sop_n !== 1 || last_len !== 4'd3 || last_half !== 1'b0) begin
            fails++;
            $display("FAIL preempt flush: sops %0d len %0d half %b, want 1 3 0", sop_n, last_len, last_half);
        end
        pulse_done;
        wait_sop(2, "cmd");
        checks++;
        if (last_half !== 1'b1) begin fails++; $display("FAIL cmd tx_half: got %b, want 1", last_half); end
        checks++;
        if (last_len !== 4'd5) begin fails++; $display("FAIL cmd tx_len: got %0d, want 5", last_len); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem[8+i] !== 16'h3C00 + 16'(i)) begin
                fails++;
                $display("FAIL cmd word%0d: got %h, want %h", i, mem[8+i], 16'h3C00 + 16'(i));
            end
        end
    endtask

    task automatic test_overflow;
        do_reset;
        cmd_pkt(1, 16'h4A00);
        repeat (3) tick;
        cmd_pkt(1, 16'h4B00);
        repeat (3) tick;
        cfg_stream_en = 1'b1;
        cfg_chmask = 8'h01;
        for (int f = 1; f <= 3; f++) begin
            frame(4, f);
            repeat (3) tick;
        end
        checks++;
        if (ovf_cnt !== 16'd2) begin fails++; $display("FAIL ovf_cnt: got %0d, want 2", ovf_cnt); end
        checks++;
        if (wr_n !== 2) begin fails++; $display("FAIL ovf stall writes: got %0d, want 2", wr_n); end
        pulse_done;
        wait_sop(2, "ovf");
        checks++;
        if (last_half !== 1'b1 || last_len !== 4'd1) begin
            fails++;
            $display("FAIL ovf second send: half %b len %0d, want 1 1", last_half, last_len);
        end
        repeat (6) tick;
        checks++;
        if (mem[0] !== ev(4, 1, 0)) begin fails++; $display("FAIL ovf resume: got %h, want %h", mem[0], ev(4, 1, 0)); end
        checks++;
        if (wr_n !== 3) begin fails++; $display("FAIL ovf resume writes: got %0d, want 3", wr_n); end
    endtask

    task automatic test_stream_off;
        do_reset;
        cfg_stream_en = 1'b1;
        cfg_chmask = 8'h03;
        frame(5, 1);
        repeat (8) tick;
        cfg_stream_en = 1'b0;
        wait_sop(1, "stream_off");
        checks++;
        if (last_len !== 4'd2 || last_half !== 1'b0) begin
            fails++;
            $display("FAIL stream_off flush: len %0d half %b, want 2 0", last_len, last_half);
        end
        cfg_stream_en = 1'b1;
        cfg_chmask = 8'hFF;
        frame(5, 2);
        repeat (2) tick;
        checks++;
        if (buf_wren !== 1'b1 || buf_wraddr !== 4'd8) begin
            fails++;
            $display("FAIL mid-strm write: wren %b addr %0d, want 1 8", buf_wren, buf_wraddr);
        end
        rst = 1'b1;
        tick;
        checks++;
        if ({buf_wren, cmd_gnt, tx_sop, tx_half} !== 4'b0 || buf_wraddr !== '0) begin
            fails++;
            $display("FAIL rst mid-strm flags/addr: got %b/%0d, want 0000/0", {buf_wren, cmd_gnt, tx_sop, tx_half}, buf_wraddr);
        end
        checks++;
        if (tx_len !== '0 || buf_wrdata !== '0 || ovf_cnt !== '0) begin
            fails++;
            $display("FAIL rst mid-strm data: len %0d data %h ovf %0d, want 0", tx_len, buf_wrdata, ovf_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_header;
        do_reset;
        cfg_stream_en = 1'b1;
        cfg_chmask = 8'h01;
        for (int f = 1; f <= 8; f++) begin
            frame(6, f);
            repeat (8) tick;
        end
        wait_sop(1, "hdr");
        checks++;
        if (last_len !== 4'd8) begin fails++; $display("FAIL hdr tx_len: got %0d, want 8", last_len); end
        checks++;
        if (mem[0] !== 16'hA500) begin fails++; $display("FAIL hdr first: got %h, want a500", mem[0]); end
        checks++;
        if (mem[1] !== ev(6, 1, 0)) begin fails++; $display("FAIL hdr word1: got %h, want %h", mem[1], ev(6, 1, 0)); end
        checks++;
        if (mem[8] !== 16'hA501) begin fails++; $display("FAIL hdr second: got %h, want a501", mem[8]); end
        checks++;
        if (mem[9] !== ev(6, 8, 0)) begin fails++; $display("FAIL hdr word9: got %h, want %h", mem[9], ev(6, 8, 0)); end
    endtask

    initial begin
        test_reset;
`ifdef TX_BUF_SCHED_HDR_EN
        test_header;
`else
        test_fill_half;
        test_frame_split;
        test_cmd_preempt;
        test_overflow;
        test_stream_off;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/tx_buf_sched.md
Name: tx_buf_sched

Overview:
- Write-side scheduler for the 2-half (ping-pong) TX buffer that feeds the USB slave FIFO.
- Shares the single buffer write port between two requesters: the command-response path and an AD7606 sample stream.
- Tracks each half's ownership and issues a start pulse to the USB side when a half is ready.
- Buffer address MSB selects the half.

Parameters:
- ADDR_NBIT, 8, word-address width within one half (half depth = 2^ADDR_NBIT).
- DATA_NBIT, 16, buffer and sample word width.
- CHN_NUM, 8, ADC channel count.

Ports:
- mclk  in  1  system clock; all logic single-clock.
- rst  in  1  synchronous, active-high reset.
- cfg_stream_en  in  1  sample streaming enable.
- cfg_chmask  in  CHN_NUM  channel select; bit i = channel i.
- ad_vd  in  1  one-cycle pulse; new sample frame, synchronous to mclk.
- ad_ch_data  in  CHN_NUM*DATA_NBIT  channel i in bits [i*DATA_NBIT +: DATA_NBIT].
- cmd_req  in  1  command path requests a packet slot.
- cmd_gnt  out  1  command path owns the write port.
- cmd_vd  in  1  command word valid; honoured only while cmd_gnt.
- cmd_data  in  DATA_NBIT  command word.
- cmd_eop  in  1  last command word; qualified by cmd_vd.
- buf_wren  out  1  buffer write enable.
- buf_wraddr  out  ADDR_NBIT+1  {half, word address}.
- buf_wrdata  out  DATA_NBIT  buffer write data.
- tx_sop  out  1  one-cycle pulse; half tx_half is ready for USB.
- tx_half  out  1  half being sent; held until tx_done.
- tx_len  out  ADDR_NBIT+1  valid word count of that half; held until tx_done.
- tx_done  in  1  one-cycle pulse; USB finished reading tx_half.
- ovf_cnt  out  16  dropped sample frames; saturates at 0xFFFF.

Behaviour:
- Reset: all outputs 0; both halves FREE; fill pointer and send pointer = half 0; capture register empty.
- Per-half state: FREE -> FILL -> READY -> SEND -> FREE.
- Halves are filled strictly in alternating order 0,1,0,… and sent in the same order.
- Writer FSM states: IDLE, CMD, STRM, FLUSH.
- IDLE arbitration priority:
  - cmd_req wins.
  - If the current fill half is non-empty, it is committed first (FLUSH, 1 cycle).
  - Then, when the next half is FREE, cmd_gnt rises and the FSM enters CMD.
  - Otherwise, a loaded capture register with a FREE/FILL half available enters STRM.
- CMD:
  - Each cmd_vd writes at the next address.
  - Words beyond 2^ADDR_NBIT are discarded.
  - cmd_eop: half -> READY with len = min(count, depth); cmd_gnt drops the next cycle; return to IDLE.
- Capture register:
  - On ad_vd with cfg_stream_en = 1, cfg_chmask != 0 and the register empty, load all channels plus the mask on the next edge.
  - If the register is full at ad_vd, drop the frame and increment ovf_cnt.
  - ad_vd with en = 0 or mask = 0 is ignored and not counted.
- STRM:
  - Writes enabled channels in ascending index order, one per cycle, without gaps.
  - First buf_wren occurs the cycle after entering STRM.
  - Worst case ad_vd -> first write is 3 cycles when idle.
  - A frame is atomic: if remaining space < popcount(mask), commit the current half first (READY) and continue in the next half.
  - If the next half is not FREE, stall with the register held.
  - A half that becomes exactly full commits immediately.
- Stream enable falling: when cfg_stream_en goes 1 -> 0, a non-empty stream half is committed via FLUSH.
- Sender:
  - When no half is in SEND and the send-pointer half is READY, pulse tx_sop and move that half to SEND.
  - tx_done moves the SEND half to FREE and advances the send pointer.
  - tx_done with no half in SEND is ignored.
- Simultaneous tx_done and commit in the same cycle are both honoured; a freed half is usable next cycle.
- rst mid-operation returns everything to the reset state; in-flight frames and packets are lost.

Optional Feature:
TX_BUF_SCHED_HDR_EN:
- Defined: every stream half starts with a header word {8'hA5, seq[7:0]}; seq increments per stream half (wraps, reset 0); header counts in tx_len and space checks.
- Undefined: no header; the half holds samples only.
- Command halves never carry a header.

Decomposition:
- Shared package tx_buf_sched_pkg: half-state enum, writer-state enum, HDR_MAGIC = 8'hA5, width constants.
- Sub-module chmask_serializer: capture register plus ascending masked-channel emitter with ready/valid toward the writer.

Test Plan:
- mask = 8'h05, four ad_vd frames, ADDR_NBIT = 3 → words ch0,ch2 ×4 fill half 0; tx_sop, tx_half = 0, tx_len = 8.
- mask = 8'h07, ADDR_NBIT = 3 → after 2 frames (6 words) the 3rd frame goes to half 1; half 0 tx_len = 6.
- cmd_req while half 0 holds 3 stream words → half 0 committed with len 3; cmd_gnt; 5-word packet in half 1 gives tx_len = 5.
- tx_done withheld, both halves READY/SEND, ad_vd ×3 → one frame held in the capture register, ovf_cnt = 2; tx_done resumes streaming.
- cfg_stream_en drops with 2 words in a half → FLUSH, tx_len = 2; rst asserted mid-STRM → all outputs 0 next cycle.
- With TX_BUF_SCHED_HDR_EN, two stream halves → first words 16'hA500, 16'hA501.
